// File: rtl/mem_pkg.sv
// Shared definitions for the memory request path: default widths and the
// request record carried from the requester to the memory port.
package mem_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_MEM_WIDTH  = 16;
    localparam int DEFAULT_DEPTH      = 8;

    typedef struct packed {
        logic                          wr_rd_en;  // 1 = write, 0 = read
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_MEM_WIDTH-1:0]  wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_sync_fifo.sv
// Generic synchronous FIFO. Pointers wrap naturally over a power-of-two
// depth; occupancy is kept in its own counter so full and empty are exact.
// Storage is not reset, only the pointers and the counter are.
module mem_sync_fifo
    import mem_pkg::*;
#(
    parameter int  DEPTH   = DEFAULT_DEPTH,
    parameter type entry_t = mem_req_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller forgets to.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Entry storage, written at the tail; deliberately without reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr] <= push_data;
    end

    // Status flags and the head entry seen by the consumer.
    always_comb begin
        full  = (count == FULL_CNT);
        empty = (count == '0);
        head  = mem_q[rd_ptr];
    end

endmodule

// File: rtl/mem_req_queue.sv
// Request queue in front of the memory model. Buffers requests in order,
// presents the oldest one to memory, and turns each completed read into a
// registered one-cycle response pulse.
//
// Handshake rule for both sides: a transfer happens at a posedge exactly when
// valid and ready are both high. The requester side sees s_ready_o low while
// full or in reset (no pass-through on a same-cycle pop). The memory side sees
// valid_o = !empty, and the head fields hold steady until the transfer.
module mem_req_queue
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int MEM_WIDTH  = DEFAULT_MEM_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic                   s_wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0]  s_addr_i,
    input  logic [MEM_WIDTH-1:0]   s_wdata_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   wr_rd_en_o,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic [MEM_WIDTH-1:0]   wdata_o,
    input  logic [MEM_WIDTH-1:0]   rdata_i,
    output logic                   rsp_valid_o,
    output logic [MEM_WIDTH-1:0]   rsp_rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    // Request record sized by this instance's parameters.
    typedef struct packed {
        logic                  wr_rd_en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [MEM_WIDTH-1:0]  wdata;
    } req_t;

    req_t push_req;
    req_t head_req;
    logic push;
    logic pop;

    // Handshake mapping between the two ports and the FIFO.
    always_comb begin
        s_ready_o  = !full_o && !rst_i;
        push       = s_valid_i && s_ready_o;
        valid_o    = !empty_o;
        pop        = valid_o && ready_i;
        push_req   = '{wr_rd_en: s_wr_rd_en_i, addr: s_addr_i, wdata: s_wdata_i};
        wr_rd_en_o = head_req.wr_rd_en;
        addr_o     = head_req.addr;
        wdata_o    = head_req.wdata;
    end

    mem_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .head      (head_req),
        .count     (count_o),
        .full      (full_o),
        .empty     (empty_o)
    );

    // Read response register; reset wins so a response due after reset is dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= pop && !head_req.wr_rd_en;
            if (pop && !head_req.wr_rd_en) rsp_rdata_o <= rdata_i;
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue: directed scenarios followed by random traffic,
// all checked each cycle against a queue-based model of the request buffer
// plus a simple array standing in for memory contents.
module tb_mem_req_queue;

    localparam int AW    = 8;
    localparam int MW    = 16;
    localparam int DEPTH = 8;
    localparam int RW    = 1 + AW + MW;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic          s_wr_rd_en_i;
    logic [AW-1:0] s_addr_i;
    logic [MW-1:0] s_wdata_i;
    logic          valid_o;
    logic          ready_i;
    logic          wr_rd_en_o;
    logic [AW-1:0] addr_o;
    logic [MW-1:0] wdata_o;
    logic [MW-1:0] rdata_i;
    logic          rsp_valid_o;
    logic [MW-1:0] rsp_rdata_o;
    logic [3:0]    count_o;
    logic          full_o;
    logic          empty_o;

    mem_req_queue #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_wr_rd_en_i (s_wr_rd_en_i),
        .s_addr_i     (s_addr_i),
        .s_wdata_i    (s_wdata_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .wr_rd_en_o   (wr_rd_en_o),
        .addr_o       (addr_o),
        .wdata_o      (wdata_o),
        .rdata_i      (rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Scoreboard state: queued requests {wr, addr, wdata} and memory contents
    logic [RW-1:0] exp_q[$];
    logic [MW-1:0] mem_model [256];
    logic          exp_rsp_valid;
    logic [MW-1:0] exp_rsp_data;
    int            total = 0;
    int            bad   = 0;
    int            pushed_cnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare every observable output with what the model says right now
    task automatic check_outputs();
        logic [RW-1:0] h;
        check_val("s_ready", 32'(s_ready_o), 32'(!rst_i && exp_q.size() < DEPTH));
        check_val("valid", 32'(valid_o), 32'(exp_q.size() != 0));
        check_val("count", 32'(count_o), 32'(exp_q.size()));
        check_val("full", 32'(full_o), 32'(exp_q.size() == DEPTH));
        check_val("empty", 32'(empty_o), 32'(exp_q.size() == 0));
        check_val("rsp_valid", 32'(rsp_valid_o), 32'(exp_rsp_valid));
        if (exp_rsp_valid) check_val("rsp_rdata", 32'(rsp_rdata_o), 32'(exp_rsp_data));
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check_val("head_wr", 32'(wr_rd_en_o), 32'(h[RW-1]));
            check_val("head_addr", 32'(addr_o), 32'(h[RW-2 -: AW]));
            check_val("head_wdata", 32'(wdata_o), 32'(h[MW-1:0]));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check
    task automatic step(input logic v, input logic wr, input logic [AW-1:0] a,
                        input logic [MW-1:0] d, input logic rdy, input logic r);
        logic          do_push;
        logic          do_pop;
        logic [RW-1:0] h;
        logic [MW-1:0] rd;
        s_valid_i    = v;
        s_wr_rd_en_i = wr;
        s_addr_i     = a;
        s_wdata_i    = d;
        ready_i      = rdy;
        rst_i        = r;
        h = '0;
        if (exp_q.size() != 0) begin
            h  = exp_q[0];
            rd = mem_model[h[RW-2 -: AW]];
        end else begin
            rd = MW'($urandom);
        end
        rdata_i = rd;
        do_push = v && !r && (exp_q.size() < DEPTH);
        do_pop  = !r && rdy && (exp_q.size() != 0);
        @(posedge clk_i);
        if (r) begin
            exp_q.delete();
            exp_rsp_valid = 1'b0;
            exp_rsp_data  = '0;
        end else begin
            exp_rsp_valid = 1'b0;
            if (do_pop) begin
                void'(exp_q.pop_front());
                if (h[RW-1]) begin
                    mem_model[h[RW-2 -: AW]] = h[MW-1:0];
                end else begin
                    exp_rsp_valid = 1'b1;
                    exp_rsp_data  = rd;
                end
            end
            if (do_push) begin
                exp_q.push_back({wr, a, d});
                pushed_cnt++;
            end
        end
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = MW'($urandom);
        exp_rsp_valid = 1'b0;
        exp_rsp_data  = '0;
        pushed_cnt    = 0;
        s_valid_i = 0; s_wr_rd_en_i = 0; s_addr_i = '0; s_wdata_i = '0;
        ready_i = 0; rdata_i = '0; rst_i = 1;
        @(negedge clk_i);

        // Reset then idle
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check_val("rst_rdata", 32'(rsp_rdata_o), 32'h0);
        idle(1'b0);
        check_val("idle_ready", 32'(s_ready_o), 32'h1);

        // Write 0xA5A5 to 0x10, then pop it
        step(1'b1, 1'b1, 8'h10, 16'hA5A5, 1'b1, 1'b0);
        check_val("wr_valid", 32'(valid_o), 32'h1);
        check_val("wr_addr", 32'(addr_o), 32'h10);
        idle(1'b1);
        check_val("wr_no_rsp", 32'(rsp_valid_o), 32'h0);

        // Read 0x10 back
        step(1'b1, 1'b0, 8'h10, 16'h0, 1'b1, 1'b0);
        idle(1'b1);
        check_val("rd_rsp_valid", 32'(rsp_valid_o), 32'h1);
        check_val("rd_rsp_data", 32'(rsp_rdata_o), 32'hA5A5);
        idle(1'b1);
        check_val("rd_rsp_pulse", 32'(rsp_valid_o), 32'h0);

        // Fill with memory stalled, try a 9th, then stream to 20 requests
        pushed_cnt = 0;
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'($urandom), 8'(i + 32), 16'($urandom), 1'b0, 1'b0);
        check_val("fill_full", 32'(full_o), 32'h1);
        check_val("fill_count", 32'(count_o), 32'h8);
        check_val("fill_ready", 32'(s_ready_o), 32'h0);
        step(1'b1, 1'b1, 8'h77, 16'h7777, 1'b0, 1'b0);
        check_val("ninth_held", 32'(count_o), 32'h8);
        while (pushed_cnt < 20)
            step(1'b1, 1'($urandom), 8'(pushed_cnt + 32), 16'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) idle(1'b1);
        check_val("drain_empty", 32'(empty_o), 32'h1);

        // Simultaneous push and pop at count 3
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'(i), 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 16'h1234, 1'b1, 1'b0);
        check_val("pp_count", 32'(count_o), 32'h3);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Reset with 5 reads queued and a read handshake in the same cycle
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 8'(i + 64), 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
        check_val("rst_count", 32'(count_o), 32'h0);
        check_val("rst_valid", 32'(valid_o), 32'h0);
        check_val("rst_rsp", 32'(rsp_valid_o), 32'h0);
        idle(1'b0);

        // Random traffic, small address range for read-after-write hits
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom_range(0, 15)),
                 16'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
        for (int i = 0; i < 10; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
